// File: rtl/uart_rx_tx.sv
// 8N1 UART transmitter and receiver sharing one clock, plus a thin top that exposes both.
// The transmitter's line and the receiver's input are separate ports so they can be looped back externally.

module uart_tx #(
    parameter int FREQ = 1_000_000,
    parameter int RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_vld,
    output logic       o_tx
);
    localparam int DIV = FREQ / RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          cnt_done;

    assign cnt_done = (cnt_reg == CNT_MAX);
    assign o_tx     = tx_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // The line register is loaded from the value the next state will drive,
    // so o_tx changes on the same edge as the state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (i_vld) begin
                    shift_next = i_data;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (cnt_done) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (cnt_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                tx_next    = 1'b1;
            end
        endcase
    end
endmodule

module uart_rx #(
    parameter int FREQ = 1_000_000,
    parameter int RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_vld
);
    localparam int DIV = FREQ / RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(DIV / 2 - 1);
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    rx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_reg, data_next;
    logic          vld_reg, vld_next;
    logic          cnt_done;

    // Synchroniser stages idle high so reset never looks like a start edge.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= i_rx;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s       = sync_reg[SYNC_STAGES-1];
    assign cnt_done   = (cnt_reg == CNT_MAX);
    assign o_data     = data_reg;
    assign o_data_vld = vld_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            vld_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            vld_reg   <= vld_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        vld_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Half a bit in: a line that has gone high again was a glitch.
                if (cnt_reg == HALF_MAX) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is not missed.
                if (cnt_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        data_next = shift_reg;
                        vld_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

module uart_rx_tx #(
    parameter int FREQ = 1_000_000,
    parameter int RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_vld,
    output logic       o_tx,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_vld
);
    uart_tx #(.FREQ(FREQ), .RATE(RATE)) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .i_vld  (i_vld),
        .o_tx   (o_tx)
    );

    uart_rx #(.FREQ(FREQ), .RATE(RATE)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_data_vld (o_data_vld)
    );
endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx: loopback and directly driven frames checked against a frame-level model.
// Line waveforms are predicted from the 8N1 bit list; received bytes are kept in queues.

module tb_uart_rx_tx;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_vld = 1'b0;
    logic       o_tx;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_data_vld;
    logic       loop_en = 1'b1;
    logic       rx_drv = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_data_q[$];
    int rx_cyc_q[$];
    int acc_q[$];

    assign i_rx = loop_en ? o_tx : rx_drv;

    uart_rx_tx #(.FREQ(1_000_000), .RATE(115_200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_vld      (i_vld),
        .o_tx       (o_tx),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_data_vld (o_data_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_data_vld === 1'b1) begin
            rx_data_q.push_back(int'(o_data));
            rx_cyc_q.push_back(cyc);
        end
    end

    // Line value for each cycle after the accept edge: ten bits of DIV cycles, then idle.
    function automatic logic [80:0] frame_wave(input logic [7:0] b);
        logic [9:0]  f;
        logic [80:0] w;
        f = {1'b1, b, 1'b0};
        for (int j = 0; j < 80; j++) w[j] = f[j / DIV];
        w[80] = 1'b1;
        return w;
    endfunction

    function automatic void clear_queues();
        rx_data_q.delete();
        rx_cyc_q.delete();
        acc_q.delete();
    endfunction

    // Called at a falling edge; returns at the falling edge after the earliest next accept slot opens.
    task automatic send_frame(input logic [7:0] b, input int inject_at, input logic [7:0] inj,
                              output logic [80:0] obs);
        i_data = b;
        i_vld  = 1'b1;
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        i_vld  = 1'b0;
        i_data = 8'($urandom);
        for (int j = 0; j <= 80; j++) begin
            @(negedge clk);
            obs[j] = o_tx;
            if (j == inject_at) begin
                i_data = inj;
                i_vld  = 1'b1;
            end else begin
                i_vld = 1'b0;
            end
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        loop_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", o_tx); end
        total++;
        if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", o_data); end
        total++;
        if (o_data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", o_data_vld); end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        total++;
        if (o_tx !== 1'b1 || o_data_vld !== 1'b0 || rx_data_q.size() != 0) begin
            bad++;
            $display("FAIL idle_after_reset tx=%b vld=%b pulses=%0d want 1/0/0", o_tx, o_data_vld, rx_data_q.size());
        end
        $display("reset: tx=%b data=%h vld=%b", o_tx, o_data, o_data_vld);
    endtask

    task automatic test_basic();
        logic [80:0] obs;
        int lat;
        clear_queues();
        send_frame(8'h6A, -1, 8'h00, obs);
        total++;
        if (obs !== frame_wave(8'h6A)) begin bad++; $display("FAIL wave_6a got=%h want=%h", obs, frame_wave(8'h6A)); end
        repeat (20) @(negedge clk);
        total++;
        if (rx_data_q.size() != 1) begin
            bad++; $display("FAIL basic_count got=%0d want=1", rx_data_q.size());
        end else begin
            lat = rx_cyc_q[0] - acc_q[0] + 1;
            total++;
            if (rx_data_q[0] != 8'h6A) begin bad++; $display("FAIL basic_data got=%h want=6a", rx_data_q[0]); end
            total++;
            if (lat < 78 || lat > 82) begin bad++; $display("FAIL basic_latency got=%0d want=78..82", lat); end
            $display("basic: byte=%h latency=%0d", rx_data_q[0], lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [3];
        logic [80:0] obs;
        int lat;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
        clear_queues();
        for (int i = 0; i < 3; i++) begin
            send_frame(bytes[i], -1, 8'h00, obs);
            total++;
            if (obs !== frame_wave(bytes[i])) begin
                bad++; $display("FAIL b2b_wave[%0d] got=%h want=%h", i, obs, frame_wave(bytes[i]));
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (rx_data_q.size() != 3) begin
            bad++; $display("FAIL b2b_count got=%0d want=3", rx_data_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                lat = rx_cyc_q[i] - acc_q[i] + 1;
                total++;
                if (rx_data_q[i] != int'(bytes[i]) || lat < 78 || lat > 82) begin
                    bad++; $display("FAIL b2b_rx[%0d] got=%h/%0d want=%h/78..82", i, rx_data_q[i], lat, bytes[i]);
                end
                if (i > 0) begin
                    total++;
                    if (rx_cyc_q[i] - rx_cyc_q[i-1] != acc_q[i] - acc_q[i-1]) begin
                        bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i,
                                        rx_cyc_q[i] - rx_cyc_q[i-1], acc_q[i] - acc_q[i-1]);
                    end
                end
                $display("b2b: byte=%h latency=%0d", rx_data_q[i], lat);
            end
        end
    endtask

    task automatic test_drop_mid_frame();
        logic [80:0] obs;
        int idle_err;
        clear_queues();
        send_frame(8'h3C, 20, 8'h55, obs);
        total++;
        if (obs !== frame_wave(8'h3C)) begin bad++; $display("FAIL drop_wave got=%h want=%h", obs, frame_wave(8'h3C)); end
        idle_err = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (o_tx !== 1'b1) idle_err++;
        end
        total++;
        if (idle_err != 0) begin bad++; $display("FAIL drop_idle low_cycles=%0d want=0", idle_err); end
        total++;
        if (rx_data_q.size() != 1 || rx_data_q[0] != 8'h3C) begin
            bad++; $display("FAIL drop_rx count=%0d first=%h want 1/3c", rx_data_q.size(),
                            (rx_data_q.size() > 0) ? rx_data_q[0] : -1);
        end
        $display("drop: line_idle_err=%0d pulses=%0d", idle_err, rx_data_q.size());
    endtask

    task automatic test_false_start();
        clear_queues();
        loop_en = 1'b0;
        rx_drv  = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (rx_data_q.size() != 0) begin bad++; $display("FAIL glitch_pulse got=%0d want=0", rx_data_q.size()); end
        drive_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (rx_data_q.size() != 1 || rx_data_q[0] != 8'hA5 || o_data !== 8'hA5) begin
            bad++; $display("FAIL after_glitch count=%0d data=%h want 1/a5", rx_data_q.size(), o_data);
        end
        $display("false_start: pulses=%0d data=%h", rx_data_q.size(), o_data);
    endtask

    task automatic test_framing_error();
        clear_queues();
        drive_frame(8'hC3, 1'b0);
        repeat (40) @(negedge clk);
        total++;
        if (rx_data_q.size() != 0) begin bad++; $display("FAIL framing_pulse got=%0d want=0", rx_data_q.size()); end
        total++;
        if (o_data !== 8'hA5) begin bad++; $display("FAIL framing_hold got=%h want=a5", o_data); end
        loop_en = 1'b1;
        $display("framing: pulses=%0d data=%h", rx_data_q.size(), o_data);
    endtask

    task automatic test_mid_reset();
        logic [80:0] obs;
        int high_err;
        clear_queues();
        loop_en = 1'b1;
        i_data  = 8'hF0;
        i_vld   = 1'b1;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        high_err = 0;
        for (int j = 0; j < 100; j++) begin
            if (o_tx !== 1'b1) high_err++;
            @(negedge clk);
        end
        total++;
        if (high_err != 0) begin bad++; $display("FAIL mid_reset_tx low_cycles=%0d want=0", high_err); end
        total++;
        if (rx_data_q.size() != 0 || o_data !== 8'h00) begin
            bad++; $display("FAIL mid_reset_rx pulses=%0d data=%h want 0/00", rx_data_q.size(), o_data);
        end
        send_frame(8'h12, -1, 8'h00, obs);
        total++;
        if (obs !== frame_wave(8'h12)) begin bad++; $display("FAIL mid_reset_wave got=%h want=%h", obs, frame_wave(8'h12)); end
        repeat (20) @(negedge clk);
        total++;
        if (rx_data_q.size() != 1 || rx_data_q[0] != 8'h12) begin
            bad++; $display("FAIL mid_reset_next count=%0d data=%h want 1/12", rx_data_q.size(), o_data);
        end
        $display("mid_reset: low_cycles=%0d next=%h", high_err, o_data);
    endtask

    task automatic test_random();
        logic [7:0]  sent [8];
        logic [80:0] obs;
        int lat;
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            sent[i] = 8'($urandom);
            send_frame(sent[i], -1, 8'h00, obs);
            total++;
            if (obs !== frame_wave(sent[i])) begin
                bad++; $display("FAIL rand_wave[%0d] got=%h want=%h", i, obs, frame_wave(sent[i]));
            end
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        total++;
        if (rx_data_q.size() != 8) begin
            bad++; $display("FAIL rand_count got=%0d want=8", rx_data_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                lat = rx_cyc_q[i] - acc_q[i] + 1;
                total++;
                if (rx_data_q[i] != int'(sent[i]) || lat < 78 || lat > 82) begin
                    bad++; $display("FAIL rand_rx[%0d] got=%h/%0d want=%h/78..82", i, rx_data_q[i], lat, sent[i]);
                end
                $display("random: byte=%h latency=%0d", rx_data_q[i], lat);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop_mid_frame();
        test_false_start();
        test_framing_error();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
